// File: rtl/monitor_clock_gen.sv
// Avalon-MM target-board clock generator: manual level, free-run divider
// and counted bursts with busy/done status and a level interrupt.
module monitor_clock_gen #(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                 state;
  logic                   level;
  logic [1:0]             mode;
  logic                   irq_en;
  logic [DIV_WIDTH-1:0]   div;
  logic [DIV_WIDTH-1:0]   phase_div;
  logic [DIV_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   count;
  logic [CNT_WIDTH-1:0]   remaining;
  logic                   busy;
  logic                   done;

  logic wr, wr_ctrl, wr_div, wr_cnt, go, clr;
  logic free, burst, phase_end, go_ok, done_set;
  logic [1:0] new_mode;

  assign wr       = chipselect & ~write_n;
  assign wr_ctrl  = wr && (address == 2'd0);
  assign wr_div   = wr && (address == 2'd1);
  assign wr_cnt   = wr && (address == 2'd2);
  assign go       = wr && (address == 2'd3) && writedata[0];
  assign clr      = wr && (address == 2'd3) && writedata[1];
  assign free     = (mode == 2'd1);
  assign burst    = (mode == 2'd2);
  assign new_mode = writedata[2:1];
  // phase length latched at each phase end, so DIV writes land on a boundary
  assign phase_end = (cnt == phase_div);
  assign go_ok     = go && burst && (state == IDLE);
  assign irq       = done & irq_en;

  always_comb begin
    done_set = 1'b0;
    if (!wr_ctrl) begin
      if (go_ok && (count == '0))
        done_set = 1'b1;
      if (burst && (state == LOW) && phase_end && (remaining == '0))
        done_set = 1'b1;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata[3:0] = {irq_en, mode, level};
      2'd1: readdata[DIV_WIDTH-1:0] = div;
      2'd2: readdata[CNT_WIDTH-1:0] = count;
      2'd3: begin
        readdata[0] = busy;
        readdata[1] = done;
        readdata[16 +: CNT_WIDTH] = remaining;
      end
      default: readdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      level     <= 1'b0;
      mode      <= 2'd0;
      irq_en    <= 1'b0;
      div       <= '0;
      phase_div <= '0;
      cnt       <= '0;
      count     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_port  <= 1'b0;
    end else begin
      done <= (done & ~clr) | done_set;
      if (wr_div) div <= writedata[DIV_WIDTH-1:0];
      if (wr_cnt) count <= writedata[CNT_WIDTH-1:0];
      if (wr_ctrl) begin
        level     <= writedata[0];
        mode      <= new_mode;
        irq_en    <= writedata[3];
        state     <= IDLE;
        cnt       <= '0;
        remaining <= '0;
        busy      <= 1'b0;
        out_port  <= (new_mode == 2'd1 || new_mode == 2'd2)
                     ? 1'b0 : writedata[0];
      end else begin
        unique case (state)
          IDLE: begin
            if (free || (go_ok && count != '0)) begin
              state     <= HIGH;
              out_port  <= 1'b1;
              busy      <= 1'b1;
              cnt       <= '0;
              phase_div <= div;
              if (!free) remaining <= count;
            end
          end
          HIGH: begin
            if (phase_end) begin
              cnt       <= '0;
              phase_div <= div;
              state     <= LOW;
              out_port  <= 1'b0;
              if (burst) remaining <= remaining - 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          LOW: begin
            if (phase_end) begin
              cnt       <= '0;
              phase_div <= div;
              if (burst && remaining == '0) begin
                state    <= IDLE;
                busy     <= 1'b0;
                out_port <= 1'b0;
              end else begin
                state    <= HIGH;
                out_port <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_monitor_clock_gen.sv
// Directed self-checking bench for monitor_clock_gen.
// Inputs change on negedge; outputs are checked on negedge.
module tb_monitor_clock_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        out_port;
  logic        irq;

  int compared = 0;
  int mismatched = 0;
  int highs;

  monitor_clock_gen #(.DIV_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp,
                    input string tag);
    address = a;
    chipselect = 1'b1;
    write_n = 1'b1;
    #1;
    chk(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    address = 2'd0;
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
    repeat (3) step();
    reset_n = 1'b1;

    // reset state
    rd(2'd0, 32'h0, "rst_ctrl");
    rd(2'd1, 32'h0, "rst_div");
    rd(2'd2, 32'h0, "rst_count");
    rd(2'd3, 32'h0, "rst_status");
    chk("rst_out", 32'(out_port), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // manual level
    wr(2'd0, 32'h1);
    chk("man_out1", 32'(out_port), 32'h1);
    rd(2'd0, 32'h1, "man_ctrl1");
    wr(2'd0, 32'h0);
    chk("man_out0", 32'(out_port), 32'h0);
    rd(2'd0, 32'h0, "man_ctrl0");

    // free-run, 3 high / 3 low, starting one edge after CTRL
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h2);
    chk("fr_idx0", 32'(out_port), 32'h0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("fr_idx%0d", k), 32'(out_port),
          32'((((k - 1) / 3) % 2) == 0));
    end
    rd(2'd3, 32'h1, "fr_busy");
    wr(2'd0, 32'h0);
    chk("fr_stop_out", 32'(out_port), 32'h0);
    rd(2'd3, 32'h0, "fr_stop_status");

    // burst of 3, 2 high / 2 low, irq enabled
    wr(2'd1, 32'd1);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'hC);
    wr(2'd3, 32'h1);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("b_out%0d", k), 32'(out_port), 32'(((k / 2) % 2) == 0));
      rd(2'd3, ((32'(3 - (k + 2) / 4)) << 16) | 32'h1,
         $sformatf("b_stat%0d", k));
      step();
    end
    chk("b_end_out", 32'(out_port), 32'h0);
    rd(2'd3, 32'h2, "b_done");
    chk("b_irq", 32'(irq), 32'h1);
    wr(2'd3, 32'h2);
    chk("b_irq_clr", 32'(irq), 32'h0);
    rd(2'd3, 32'h0, "b_clr_status");

    // GO with COUNT=0
    wr(2'd2, 32'd0);
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h2, "z_done");
    chk("z_out", 32'(out_port), 32'h0);
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h0, "z_clr");

    // second GO mid-burst is ignored
    wr(2'd2, 32'd2);
    wr(2'd3, 32'h1);
    highs = 32'(out_port);
    step();
    highs += 32'(out_port);
    wr(2'd3, 32'h1);
    for (int k = 2; k < 10; k++) begin
      highs += 32'(out_port);
      step();
    end
    chk("g2_highs", 32'(highs), 32'd4);
    rd(2'd3, 32'h2, "g2_done");
    wr(2'd3, 32'h2);

    // reset mid-burst
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h4);
    wr(2'd3, 32'h1);
    step();
    step();
    chk("r_pre_out", 32'(out_port), 32'h1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("r_out", 32'(out_port), 32'h0);
    rd(2'd3, 32'h0, "r_status");
    rd(2'd1, 32'h0, "r_div");
    rd(2'd0, 32'h0, "r_ctrl");
    chk("r_irq", 32'(irq), 32'h0);

    // DIV change mid-phase applies at next phase boundary
    wr(2'd1, 32'd1);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h4);
    wr(2'd3, 32'h1);
    chk("d_idx0", 32'(out_port), 32'h1);
    wr(2'd1, 32'd3);
    chk("d_idx1", 32'(out_port), 32'h1);
    for (int k = 2; k <= 13; k++) begin
      step();
      chk($sformatf("d_idx%0d", k), 32'(out_port), 32'(k >= 6 && k <= 9));
    end
    step();
    rd(2'd3, 32'h2, "d_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
